// File: rtl/ldtu_frame_fsm.sv
// LiTe-DTU frame sequencer: baseline/signal framing with a slot counter, BC0/header
// insertion on Orbit, frame-close reporting, and a fallback word sequencer.
module ldtu_frame_fsm #(
  parameter int N_BAS  = 5,
  parameter int N_SIG  = 2,
  parameter int FB_LAT = 1,
  parameter int IDXW   = ($clog2((N_BAS > N_SIG) ? N_BAS : N_SIG) < 1) ? 1
                         : $clog2((N_BAS > N_SIG) ? N_BAS : N_SIG)
) (
  input  logic            CLK,
  input  logic            rst_b,
  input  logic            fallback,
  input  logic            Orbit,
  input  logic            baseline_flag,
  output logic [2:0]      state,
  output logic [IDXW-1:0] slot,
  output logic            frame_done,
  output logic            frame_trunc,
  output logic [IDXW:0]   n_valid,
  output logic            orbit_drop,
  output logic [1:0]      fb_state,
  output logic            fb_parity
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_BAS = 3'd1, S_SIG = 3'd2, S_BC0 = 3'd3, S_HDR = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FB_IDLE = 2'd0, FB_DATA = 2'd1, FB_WAIT = 2'd2
  } fb_e;

  localparam int              NVW      = IDXW + 1;
  localparam int              LAT_M1   = (FB_LAT > 0) ? FB_LAT - 1 : 0;
  localparam logic [IDXW-1:0] LAST_BAS = IDXW'(N_BAS - 1);
  localparam logic [IDXW-1:0] LAST_SIG = IDXW'(N_SIG - 1);
  localparam logic [NVW-1:0]  FULL_BAS = NVW'(N_BAS);
  localparam logic [NVW-1:0]  FULL_SIG = NVW'(N_SIG);
  localparam logic [2:0]      LAT_LOAD = 3'(LAT_M1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] slot_q, slot_d;
  logic            done_q, done_d;
  logic            trunc_q, trunc_d;
  logic [NVW-1:0]  nval_q, nval_d;
  logic            drop_q, drop_d;
  fb_e             fb_q, fb_d;
  logic            par_q, par_d;
  logic [2:0]      cnt_q, cnt_d;

  logic [NVW-1:0]  slot_cnt;
  assign slot_cnt = NVW'(slot_q) + NVW'(1);

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
      nval_q  <= '0;
      drop_q  <= 1'b0;
      fb_q    <= FB_IDLE;
      par_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
      trunc_q <= trunc_d;
      nval_q  <= nval_d;
      drop_q  <= drop_d;
      fb_q    <= fb_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    slot_d  = '0;
    done_d  = 1'b0;
    trunc_d = 1'b0;
    nval_d  = '0;
    drop_d  = 1'b0;
    fb_d    = FB_IDLE;
    par_d   = 1'b0;
    cnt_d   = 3'd0;

    if (!fallback) begin
      // Orbit pre-empts class decisions everywhere except inside the BC0/HDR insertion
      case (state_q)
        S_IDLE: begin
          if (Orbit)              state_d = S_HDR;
          else if (baseline_flag) state_d = S_BAS;
          else                    state_d = S_SIG;
        end
        S_BAS: begin
          if (Orbit) begin
            state_d = S_BC0;
            trunc_d = 1'b1;
            nval_d  = slot_cnt;
          end else if (baseline_flag) begin
            state_d = S_BAS;
            if (slot_q >= LAST_BAS) begin
              done_d = 1'b1;
              nval_d = FULL_BAS;
            end else begin
              slot_d = slot_q + IDXW'(1);
            end
          end else begin
            state_d = S_SIG;
            trunc_d = 1'b1;
            nval_d  = slot_cnt;
          end
        end
        S_SIG: begin
          if (Orbit) begin
            state_d = S_BC0;
            trunc_d = 1'b1;
            nval_d  = slot_cnt;
          end else if (!baseline_flag) begin
            state_d = S_SIG;
            if (slot_q >= LAST_SIG) begin
              done_d = 1'b1;
              nval_d = FULL_SIG;
            end else begin
              slot_d = slot_q + IDXW'(1);
            end
          end else begin
            state_d = S_BAS;
            trunc_d = 1'b1;
            nval_d  = slot_cnt;
          end
        end
        S_BC0: begin
          state_d = S_HDR;
          drop_d  = Orbit;
        end
        S_HDR: begin
          state_d = baseline_flag ? S_BAS : S_SIG;
          drop_d  = Orbit;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      par_d = par_q;
      cnt_d = cnt_q;
      case (fb_q)
        FB_IDLE: begin
          fb_d  = FB_DATA;
          par_d = 1'b0;
        end
        FB_DATA: begin
          if (FB_LAT > 0) begin
            fb_d  = FB_WAIT;
            cnt_d = LAT_LOAD;
          end else begin
            fb_d  = FB_DATA;
            par_d = ~par_q;
          end
        end
        FB_WAIT: begin
          if (cnt_q == 3'd0) begin
            fb_d  = FB_DATA;
            par_d = ~par_q;
          end else begin
            fb_d  = FB_WAIT;
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          fb_d  = FB_IDLE;
          par_d = 1'b0;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign slot        = slot_q;
  assign frame_done  = done_q;
  assign frame_trunc = trunc_q;
  assign n_valid     = nval_q;
  assign orbit_drop  = drop_q;
  assign fb_state    = fb_q;
  assign fb_parity   = par_q;

endmodule

// File: tb/tb_ldtu_frame_fsm.sv
// Bench for ldtu_frame_fsm: directed scenarios on two parameter sets plus a
// randomized run against a frame-level reference model.
module tb_ldtu_frame_fsm;

  logic       CLK = 1'b0;
  logic       rst_b, fallback, Orbit, baseline_flag;
  logic [2:0] st [2];
  logic [2:0] sl [2];
  logic       fd [2];
  logic       ft [2];
  logic [3:0] nv [2];
  logic       od [2];
  logic [1:0] fs [2];
  logic       fp [2];

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  ldtu_frame_fsm #(.N_BAS(5), .N_SIG(2), .FB_LAT(1)) dut (
    .CLK(CLK), .rst_b(rst_b), .fallback(fallback), .Orbit(Orbit),
    .baseline_flag(baseline_flag), .state(st[0]), .slot(sl[0]),
    .frame_done(fd[0]), .frame_trunc(ft[0]), .n_valid(nv[0]),
    .orbit_drop(od[0]), .fb_state(fs[0]), .fb_parity(fp[0])
  );

  ldtu_frame_fsm #(.N_BAS(5), .N_SIG(1), .FB_LAT(0)) dut0 (
    .CLK(CLK), .rst_b(rst_b), .fallback(fallback), .Orbit(Orbit),
    .baseline_flag(baseline_flag), .state(st[1]), .slot(sl[1]),
    .frame_done(fd[1]), .frame_trunc(ft[1]), .n_valid(nv[1]),
    .orbit_drop(od[1]), .fb_state(fs[1]), .fb_parity(fp[1])
  );

  // Reference model: open-frame class and sample count, fallback word count.
  int m_nb [2] = '{5, 5};
  int m_ns [2] = '{2, 1};
  int m_fl [2] = '{1, 0};
  int m_kind [2];
  int m_cnt [2];
  int m_fbk [2];
  int m_lat [2];
  int m_words [2];
  int m_nv [2];
  bit m_done [2];
  bit m_trunc [2];
  bit m_drop [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_kind[i] = 0; m_cnt[i] = 0; m_fbk[i] = 0; m_lat[i] = 0; m_words[i] = 0;
      m_nv[i] = 0; m_done[i] = 0; m_trunc[i] = 0; m_drop[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit fb, input bit orb, input bit flag);
    int want, limit;
    m_done[i] = 0; m_trunc[i] = 0; m_drop[i] = 0; m_nv[i] = 0;
    if (fb) begin
      m_kind[i] = 0; m_cnt[i] = 0;
      if (m_fbk[i] == 0) begin
        m_fbk[i] = 1; m_words[i] = 1;
      end else if (m_fbk[i] == 1) begin
        if (m_fl[i] > 0) begin m_fbk[i] = 2; m_lat[i] = m_fl[i]; end
        else m_words[i]++;
      end else begin
        m_lat[i]--;
        if (m_lat[i] == 0) begin m_fbk[i] = 1; m_words[i]++; end
      end
    end else begin
      m_fbk[i] = 0; m_words[i] = 0; m_lat[i] = 0;
      want = flag ? 1 : 2;
      if (m_kind[i] == 0) begin
        if (orb) m_kind[i] = 4;
        else begin m_kind[i] = want; m_cnt[i] = 1; end
      end else if (m_kind[i] == 1 || m_kind[i] == 2) begin
        limit = (m_kind[i] == 1) ? m_nb[i] : m_ns[i];
        if (orb) begin
          m_trunc[i] = 1; m_nv[i] = m_cnt[i]; m_kind[i] = 3; m_cnt[i] = 0;
        end else if (want == m_kind[i]) begin
          if (m_cnt[i] == limit) begin m_done[i] = 1; m_nv[i] = limit; m_cnt[i] = 1; end
          else m_cnt[i]++;
        end else begin
          m_trunc[i] = 1; m_nv[i] = m_cnt[i]; m_kind[i] = want; m_cnt[i] = 1;
        end
      end else if (m_kind[i] == 3) begin
        m_drop[i] = orb; m_kind[i] = 4;
      end else begin
        m_drop[i] = orb; m_kind[i] = want; m_cnt[i] = 1;
      end
    end
  endtask

  typedef struct packed {
    logic       fb;
    logic       orb;
    logic       flag;
    logic [2:0] st;
    logic [2:0] sl;
    logic       done;
    logic       trunc;
    logic       drop;
    logic [3:0] nv;
  } vec_t;

  function automatic vec_t mk(bit fb, bit orb, bit flag, int s, int k,
                              bit done, bit trunc, bit drop, int n);
    vec_t v;
    v.fb = fb; v.orb = orb; v.flag = flag; v.st = 3'(s); v.sl = 3'(k);
    v.done = done; v.trunc = trunc; v.drop = drop; v.nv = 4'(n);
    return v;
  endfunction

  task automatic step(input bit fb, input bit orb, input bit flag);
    fallback = fb; Orbit = orb; baseline_flag = flag;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    fallback = 1'b0; Orbit = 1'b0; baseline_flag = 1'b0;
    rst_b = 1'b0;
    @(posedge CLK);
    #1;
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    fallback = 1'b0; Orbit = 1'b0; baseline_flag = 1'b0; rst_b = 1'b1;
    #2 rst_b = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({st[i], sl[i], fd[i], ft[i], nv[i], od[i], fs[i], fp[i]} !== 16'h0)
        $display("FAIL reset_async inst%0d: got st=%0d slot=%0d fb=%0d nv=%0d, expected all 0",
                 i, st[i], sl[i], fs[i], nv[i]);
      else n_pass++;
    end
    @(posedge CLK);
    #1;
    rst_b = 1'b1;
    step(0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({st[i], sl[i], ft[i]} !== {3'd1, 3'd0, 1'b0})
        $display("FAIL reset_release inst%0d: got st=%0d slot=%0d, expected st=1 slot=0", i, st[i], sl[i]);
      else n_pass++;
    end
    step(0, 0, 1);
    step(0, 0, 1);
    #2 rst_b = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({st[i], sl[i], fd[i], ft[i], nv[i], od[i], fs[i], fp[i]} !== 16'h0)
        $display("FAIL reset_midframe inst%0d: got st=%0d slot=%0d trunc=%0b, expected all 0",
                 i, st[i], sl[i], ft[i]);
      else n_pass++;
    end
    @(posedge CLK);
    #1;
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic test_baseline_frames();
    logic [2:0] es;
    logic       ed;
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      step(0, 0, 1);
      es = 3'((c - 1) % 5);
      ed = (c == 6) || (c == 11);
      n_total++;
      if ({st[0], sl[0], fd[0], ft[0]} !== {3'd1, es, ed, 1'b0})
        $display("FAIL bas_frame cyc%0d: got st=%0d slot=%0d done=%0b trunc=%0b, expected st=1 slot=%0d done=%0b trunc=0",
                 c, st[0], sl[0], fd[0], ft[0], es, ed);
      else n_pass++;
      if (ed) begin
        n_total++;
        if (nv[0] !== 4'd5) $display("FAIL bas_nvalid cyc%0d: got %0d expected 5", c, nv[0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_truncation();
    vec_t v[$];
    do_reset();
    v.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 1, 2, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 2, 0, 0, 1, 0, 3));
    v.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 0, 2, 0, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 0, 2, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 2, 0, 1, 0, 0, 2));
    foreach (v[k]) begin
      step(v[k].fb, v[k].orb, v[k].flag);
      n_total++;
      if ({st[0], sl[0], fd[0], ft[0], od[0]} !== {v[k].st, v[k].sl, v[k].done, v[k].trunc, v[k].drop})
        $display("FAIL trunc_seq step%0d: got st=%0d slot=%0d done=%0b trunc=%0b, expected st=%0d slot=%0d done=%0b trunc=%0b",
                 k, st[0], sl[0], fd[0], ft[0], v[k].st, v[k].sl, v[k].done, v[k].trunc);
      else n_pass++;
      if (v[k].done || v[k].trunc) begin
        n_total++;
        if (nv[0] !== v[k].nv) $display("FAIL trunc_nvalid step%0d: got %0d expected %0d", k, nv[0], v[k].nv);
        else n_pass++;
      end
    end
  endtask

  task automatic test_orbit();
    vec_t v[$];
    do_reset();
    v.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 2, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 1, 3, 0, 0, 1, 0, 2));
    v.push_back(mk(0, 1, 1, 4, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 1, 3, 0, 0, 1, 0, 2));
    v.push_back(mk(0, 0, 0, 4, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 4, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 0));
    foreach (v[k]) begin
      step(v[k].fb, v[k].orb, v[k].flag);
      n_total++;
      if ({st[0], sl[0], fd[0], ft[0], od[0]} !== {v[k].st, v[k].sl, v[k].done, v[k].trunc, v[k].drop})
        $display("FAIL orbit_seq step%0d: got st=%0d slot=%0d trunc=%0b drop=%0b, expected st=%0d slot=%0d trunc=%0b drop=%0b",
                 k, st[0], sl[0], ft[0], od[0], v[k].st, v[k].sl, v[k].trunc, v[k].drop);
      else n_pass++;
      if (v[k].done || v[k].trunc) begin
        n_total++;
        if (nv[0] !== v[k].nv) $display("FAIL orbit_nvalid step%0d: got %0d expected %0d", k, nv[0], v[k].nv);
        else n_pass++;
      end
    end
  endtask

  task automatic test_fallback();
    int         efs [2][5] = '{'{1, 2, 1, 2, 1}, '{1, 1, 1, 1, 1}};
    int         efp [2][5] = '{'{0, 0, 1, 1, 0}, '{0, 1, 0, 1, 0}};
    logic [9:0] exp;
    do_reset();
    for (int c = 0; c < 4; c++) step(0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 2; i++) begin
        exp = {3'd0, 3'd0, 1'b0, 1'b0, 2'(efs[i][c])};
        n_total++;
        if ({st[i], sl[i], fd[i], ft[i], fs[i]} !== exp || fp[i] !== 1'(efp[i][c]))
          $display("FAIL fallback inst%0d cyc%0d: got st=%0d slot=%0d trunc=%0b fb=%0d par=%0b, expected st=0 slot=0 trunc=0 fb=%0d par=%0d",
                   i, c, st[i], sl[i], ft[i], fs[i], fp[i], efs[i][c], efp[i][c]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mode_return();
    vec_t v[$];
    v.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 4, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 0));
    foreach (v[k]) begin
      step(v[k].fb, v[k].orb, v[k].flag);
      for (int i = 0; i < 2; i++) begin
        n_total++;
        if ({st[i], sl[i], ft[i], od[i], fs[i], fp[i]} !== {v[k].st, v[k].sl, 1'b0, 1'b0, v[k].fb ? 2'd1 : 2'd0, 1'b0})
          $display("FAIL mode_return inst%0d step%0d: got st=%0d slot=%0d fb=%0d par=%0b, expected st=%0d slot=%0d fb=%0d par=0",
                   i, k, st[i], sl[i], fs[i], fp[i], v[k].st, v[k].sl, v[k].fb);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    bit          fbv = 0, flagv = 1, orb;
    int          exp_slot;
    bit          exp_par;
    logic [11:0] exp, act;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 39) == 0) fbv = ~fbv;
      if ($urandom_range(0, flagv ? 9 : 2) == 0) flagv = ~flagv;
      orb = ($urandom_range(0, 9) == 0);
      step(fbv, orb, flagv);
      for (int i = 0; i < 2; i++) begin
        model_step(i, fbv, orb, flagv);
        exp_slot = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        exp_par  = (m_words[i] > 0) && (m_words[i] % 2 == 0);
        exp = {3'(m_kind[i]), 3'(exp_slot), m_done[i], m_trunc[i], m_drop[i], 2'(m_fbk[i]), exp_par};
        act = {st[i], sl[i], fd[i], ft[i], od[i], fs[i], fp[i]};
        n_total++;
        if (act !== exp)
          $display("FAIL random inst%0d cyc%0d: got {st,slot,done,trunc,drop,fb,par}=%h, expected %h", i, c, act, exp);
        else n_pass++;
        if (m_done[i] || m_trunc[i]) begin
          n_total++;
          if (nv[i] !== 4'(m_nv[i]))
            $display("FAIL random_nvalid inst%0d cyc%0d: got %0d expected %0d", i, c, nv[i], m_nv[i]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_baseline_frames();
    test_truncation();
    test_orbit();
    test_fallback();
    test_mode_return();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
